sensor_conditioner: RTL and testbench

Per-direction vehicle-sensor conditioner that sits directly upstream of `traffic_light_controller`. It takes the five raw loop-detector inputs, applies assert/release debouncing, and drives the controller's five sensor inputs. Each channel also has a stuck-detector that masks a loop held high continuously and raises a fault flag for maintenance.

---
 rtl/sensor_conditioner.sv | 186 ++++++++++++++++++
 tb/tb_sensor_conditioner.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sensor_conditioner.sv
// Five-channel loop-detector conditioner: assert/release debounce plus a
// stuck-loop detector that masks a continuously-high loop and flags it.

module sensor_conditioner_chan #(
    parameter int unsigned ON_CYCLES    = 3,
    parameter int unsigned OFF_CYCLES   = 4,
    parameter int unsigned STUCK_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic sensor_o,
    output logic fault_o
);

    localparam int unsigned W = $clog2(STUCK_CYCLES + 1);
    localparam logic [W-1:0] ONE       = W'(1);
    localparam logic [W-1:0] ON_LAST   = W'(ON_CYCLES - 1);
    localparam logic [W-1:0] OFF_LAST  = W'(OFF_CYCLES - 1);
    localparam logic [W-1:0] STUCK_MAX = W'(STUCK_CYCLES);

    typedef enum logic [2:0] {
        ABSENT,
        ARMING,
        PRESENT,
        HOLD,
        FAULT
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] dcnt_q, dcnt_d;
    logic [W-1:0] scnt_q, scnt_d;
    logic         sensor_q, sensor_d;
    logic         fault_q, fault_d;
    logic         stuck_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ABSENT;
            dcnt_q   <= '0;
            scnt_q   <= '0;
            sensor_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            scnt_q   <= scnt_d;
            sensor_q <= sensor_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        scnt_d    = scnt_q;
        stuck_hit = 1'b0;

        // scnt is frozen in FAULT; the FAULT exit clears it explicitly below
        if (state_q != FAULT) begin
            if (raw_i) begin
                scnt_d = (scnt_q == STUCK_MAX) ? scnt_q : scnt_q + ONE;
            end else begin
                scnt_d = '0;
            end
            stuck_hit = raw_i && (scnt_d == STUCK_MAX);
        end

        case (state_q)
            ABSENT: begin
                if (raw_i) begin
                    if (ON_CYCLES == 1) begin
                        state_d = PRESENT;
                        dcnt_d  = '0;
                    end else begin
                        state_d = ARMING;
                        dcnt_d  = ONE;
                    end
                end
            end
            ARMING: begin
                if (!raw_i) begin
                    state_d = ABSENT;
                    dcnt_d  = '0;
                end else if (dcnt_q == ON_LAST) begin
                    state_d = PRESENT;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + ONE;
                end
            end
            PRESENT: begin
                if (!raw_i) begin
                    if (OFF_CYCLES == 1) begin
                        state_d = ABSENT;
                        dcnt_d  = '0;
                    end else begin
                        state_d = HOLD;
                        dcnt_d  = ONE;
                    end
                end
            end
            HOLD: begin
                if (raw_i) begin
                    state_d = PRESENT;
                    dcnt_d  = '0;
                end else if (dcnt_q == OFF_LAST) begin
                    state_d = ABSENT;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + ONE;
                end
            end
            FAULT: begin
                if (!raw_i) begin
                    state_d = ABSENT;
                    dcnt_d  = '0;
                    scnt_d  = '0;
                end
            end
            default: begin
                state_d = ABSENT;
                dcnt_d  = '0;
                scnt_d  = '0;
            end
        endcase

        // A loop reaching the stuck limit overrides any debounce decision
        if ((state_q == ARMING || state_q == PRESENT || state_q == HOLD) && stuck_hit) begin
            state_d = FAULT;
            dcnt_d  = '0;
        end

        sensor_d = (state_d == PRESENT) || (state_d == HOLD);
        fault_d  = (state_d == FAULT);
    end

    assign sensor_o = sensor_q;
    assign fault_o  = fault_q;

endmodule

module sensor_conditioner #(
    parameter int unsigned ON_CYCLES    = 3,
    parameter int unsigned OFF_CYCLES   = 4,
    parameter int unsigned STUCK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e_left_raw,
    input  logic       e_straight_raw,
    input  logic       w_left_raw,
    input  logic       w_straight_raw,
    input  logic       ns_raw,
    output logic       e_left_sensor,
    output logic       e_straight_sensor,
    output logic       w_left_sensor,
    output logic       w_straight_sensor,
    output logic       ns_sensor,
    output logic [4:0] stuck_fault
);

    logic [4:0] raw_vec;
    logic [4:0] sensor_vec;
    logic [4:0] fault_vec;

    assign raw_vec = {e_left_raw, e_straight_raw, w_left_raw, w_straight_raw, ns_raw};

    for (genvar i = 0; i < 5; i++) begin : g_chan
        sensor_conditioner_chan #(
            .ON_CYCLES   (ON_CYCLES),
            .OFF_CYCLES  (OFF_CYCLES),
            .STUCK_CYCLES(STUCK_CYCLES)
        ) u_chan (
            .clk_i   (clk),
            .rst_ni  (reset),
            .raw_i   (raw_vec[i]),
            .sensor_o(sensor_vec[i]),
            .fault_o (fault_vec[i])
        );
    end

    assign {e_left_sensor, e_straight_sensor, w_left_sensor, w_straight_sensor, ns_sensor} = sensor_vec;
    assign stuck_fault = fault_vec;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: stimulus pushes the expected
// post-edge outputs, a monitor pops and compares one entry per clock.

module tb_sensor_conditioner;

    typedef struct {
        logic [4:0] s;
        logic [4:0] f;
        string      tag;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [4:0] raw;
    logic       e_left_sensor, e_straight_sensor, w_left_sensor, w_straight_sensor, ns_sensor;
    logic [4:0] stuck_fault;
    logic [4:0] act_s;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    sensor_conditioner #(
        .ON_CYCLES   (3),
        .OFF_CYCLES  (4),
        .STUCK_CYCLES(16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .e_left_raw       (raw[4]),
        .e_straight_raw   (raw[3]),
        .w_left_raw       (raw[2]),
        .w_straight_raw   (raw[1]),
        .ns_raw           (raw[0]),
        .e_left_sensor    (e_left_sensor),
        .e_straight_sensor(e_straight_sensor),
        .w_left_sensor    (w_left_sensor),
        .w_straight_sensor(w_straight_sensor),
        .ns_sensor        (ns_sensor),
        .stuck_fault      (stuck_fault)
    );

    assign act_s = {e_left_sensor, e_straight_sensor, w_left_sensor, w_straight_sensor, ns_sensor};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [4:0] r, input logic [4:0] es, input logic [4:0] ef,
                        input string tag);
        exp_t e;
        @(negedge clk);
        raw   = r;
        e.s   = es;
        e.f   = ef;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Monitor: one expected entry per rising edge, sampled just after it
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, "_sensor"}, act_s, e.s);
                check({e.tag, "_fault"}, stuck_fault, e.f);
            end
        end
    end

    initial begin
        exp_t e;
        reset = 1'b0;
        raw   = 5'h1F;

        // 1: held in reset with all raw high, released mid-cycle
        for (int i = 0; i < 3; i++) step(5'h1F, 5'h00, 5'h00, "t1_inreset");
        @(negedge clk);
        e.s = 5'h00; e.f = 5'h00; e.tag = "t1_edge1";
        sb.push_back(e);
        #2 reset = 1'b1;
        step(5'h1F, 5'h00, 5'h00, "t1_edge2");
        step(5'h1F, 5'h1F, 5'h00, "t1_edge3");
        step(5'h00, 5'h1F, 5'h00, "t1_low1");
        step(5'h00, 5'h1F, 5'h00, "t1_low2");
        step(5'h00, 5'h1F, 5'h00, "t1_low3");
        step(5'h00, 5'h00, 5'h00, "t1_low4");
        step(5'h00, 5'h00, 5'h00, "t1_idle");

        // 2: short pulse rejected, 3-cycle pulse accepted on e_left
        step(5'b10000, 5'h00, 5'h00, "t2_short");
        step(5'b10000, 5'h00, 5'h00, "t2_short");
        step(5'b00000, 5'h00, 5'h00, "t2_gap");
        step(5'b00000, 5'h00, 5'h00, "t2_gap");
        step(5'b10000, 5'h00, 5'h00, "t2_on1");
        step(5'b10000, 5'h00, 5'h00, "t2_on2");
        step(5'b10000, 5'b10000, 5'h00, "t2_on3");
        step(5'b00000, 5'b10000, 5'h00, "t2_off1");
        step(5'b00000, 5'b10000, 5'h00, "t2_off2");
        step(5'b00000, 5'b10000, 5'h00, "t2_off3");
        step(5'b00000, 5'h00, 5'h00, "t2_off4");

        // 3: ns with a 3-cycle low gap holds through
        step(5'b00001, 5'h00, 5'h00, "t3_on1");
        step(5'b00001, 5'h00, 5'h00, "t3_on2");
        step(5'b00001, 5'b00001, 5'h00, "t3_on3");
        step(5'b00001, 5'b00001, 5'h00, "t3_on4");
        for (int i = 0; i < 3; i++) step(5'b00000, 5'b00001, 5'h00, "t3_gap");
        for (int i = 0; i < 4; i++) step(5'b00001, 5'b00001, 5'h00, "t3_high");
        for (int i = 0; i < 3; i++) step(5'b00000, 5'b00001, 5'h00, "t3_fall");
        step(5'b00000, 5'h00, 5'h00, "t3_fall4");

        // 4: w_straight stuck high for 20 samples
        for (int i = 1; i <= 20; i++)
            step(5'b00010, (i >= 3 && i <= 15) ? 5'b00010 : 5'h00,
                 (i >= 16) ? 5'b00010 : 5'h00, "t4_stuck");
        step(5'b00000, 5'h00, 5'h00, "t4_clear");
        step(5'b00000, 5'h00, 5'h00, "t4_idle");
        step(5'b00010, 5'h00, 5'h00, "t4_re1");
        step(5'b00010, 5'h00, 5'h00, "t4_re2");
        step(5'b00010, 5'b00010, 5'h00, "t4_re3");
        for (int i = 0; i < 3; i++) step(5'b00000, 5'b00010, 5'h00, "t4_rel");
        step(5'b00000, 5'h00, 5'h00, "t4_rel4");

        // 5: all rise together, short asynchronous reset mid-PRESENT
        step(5'h1F, 5'h00, 5'h00, "t5_on1");
        step(5'h1F, 5'h00, 5'h00, "t5_on2");
        step(5'h1F, 5'h1F, 5'h00, "t5_on3");
        step(5'h1F, 5'h1F, 5'h00, "t5_on4");
        @(negedge clk);
        e.s = 5'h00; e.f = 5'h00; e.tag = "t5_post1";
        sb.push_back(e);
        #2 reset = 1'b0;
        #0.5;
        check("t5_async_sensor", act_s, 5'h00);
        check("t5_async_fault", stuck_fault, 5'h00);
        #0.5 reset = 1'b1;
        step(5'h1F, 5'h00, 5'h00, "t5_post2");
        step(5'h1F, 5'h1F, 5'h00, "t5_post3");
        for (int i = 0; i < 3; i++) step(5'h00, 5'h1F, 5'h00, "t5_rel");
        step(5'h00, 5'h00, 5'h00, "t5_rel4");

        // 6: single-cycle glitches on all channels, idle and present
        step(5'h1F, 5'h00, 5'h00, "t6_hglitch");
        step(5'h00, 5'h00, 5'h00, "t6_idle");
        step(5'b10101, 5'h00, 5'h00, "t6_alt_a");
        step(5'b01010, 5'h00, 5'h00, "t6_alt_b");
        step(5'h00, 5'h00, 5'h00, "t6_idle2");
        step(5'h1F, 5'h00, 5'h00, "t6_on1");
        step(5'h1F, 5'h00, 5'h00, "t6_on2");
        step(5'h1F, 5'h1F, 5'h00, "t6_on3");
        step(5'b01010, 5'h1F, 5'h00, "t6_lglitch_a");
        step(5'h1F, 5'h1F, 5'h00, "t6_back_a");
        step(5'b10101, 5'h1F, 5'h00, "t6_lglitch_b");
        step(5'h1F, 5'h1F, 5'h00, "t6_back_b");
        for (int i = 0; i < 3; i++) step(5'h00, 5'h1F, 5'h00, "t6_rel");
        step(5'h00, 5'h00, 5'h00, "t6_rel4");

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #3;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
